coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Memory-side controller directly downstream of the per-core cache blocks (icache + dcache pair per core).
- Arbitrates instruction fetches, dcache fills and dcache writebacks from two cores onto a single RAM port.
- Runs MSI snooping between the two dcaches, including cache-to-cache transfer of Modified blocks.
- One transaction in flight at a time; blocks are two words, moved one word per RAM access.

Parameters:
CPUS, 2, number of cores; only 2 supported
WORD_W, 32, data/address width

Ports:
CLK  in  1  clock
nRST  in  1  reset; one clock; reset is synchronous and active-low
iREN  in  CPUS  icache read request, per core
iaddr  in  CPUS*WORD_W  icache word address, per core
iwait  out  CPUS  low for one cycle when iload is valid
iload  out  CPUS*WORD_W  instruction word
dREN  in  CPUS  dcache read (fill) request
dWEN  in  CPUS  dcache write (writeback or snoop supply) request
daddr  in  CPUS*WORD_W  dcache word address
dstore  in  CPUS*WORD_W  dcache write data
dwait  out  CPUS  low for one cycle when a dcache word completes
dload  out  CPUS*WORD_W  dcache fill data
ccwrite  in  CPUS  requester intends to write (fill for M)
cctrans  in  CPUS  fill is a coherence miss (request) / snoop response ready (snooper)
ccwait  out  CPUS  core is being snooped; its cache must service the snoop
ccinv  out  CPUS  snooped block must be invalidated
ccsnoopaddr  out  CPUS*WORD_W  snoop address
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset values: all wait outputs 1; ccwait, ccinv, ramREN and ramWEN 0; ccsnoopaddr 0; state IDLE; both round-robin pointers 0. Reset mid-transaction aborts it with no completion pulse.
- iload[n] and dload[n] are combinational copies of ramload, except dload[req] during C2C (see below).
- IDLE, priority order:
  - any dWEN -> WB0 (writer = round-robin among dWEN);
  - else any dREN -> SNOOP (req = round-robin among dREN);
  - else any iREN -> IF (req = icache round-robin).
- Sampling: requester index and address are captured at the IDLE exit; the cache holds the address stable per word.
- WB0/WB1:
  - ramWEN=1, ramaddr=daddr[w], ramstore=dstore[w].
  - On ramstate==ACCESS: dwait[w]=0 for that cycle; WB0->WB1, WB1->IDLE.
- SNOOP:
  - o = other core; ccwait[o]=1, ccsnoopaddr[o]=daddr[req], ccinv[o]=ccwrite[req].
  - Stays until cctrans[o]=1; then dWEN[o] -> C2C0, else -> LD0.
- LD0/LD1:
  - ramREN=1, ramaddr=daddr[req]; ccwait[o] held.
  - On ACCESS: dwait[req]=0; LD0->LD1, LD1->IDLE.
- C2C0/C2C1:
  - ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o]; dload[req]=dstore[o]; ccwait[o] held.
  - On ACCESS: dwait[o]=0 and dwait[req]=0 in the same cycle; C2C0->C2C1, C2C1->IDLE.
- IF: ramREN=1, ramaddr=iaddr[req]; on ACCESS iwait[req]=0, -> IDLE.
- Round-robin pointers: the dcache pointer toggles after completing a WB, LD or C2C transaction; the icache pointer toggles after IF. The granted core becomes lowest priority.
- Ready condition: ramstate FREE, BUSY or ERROR is treated as not-ready, so the controller stalls in the current state.
- Latency: minimum 1 cycle from request to grant; completion pulses follow ramstate==ACCESS combinationally.
- Port exclusivity: ramREN and ramWEN are never both 1; every non-granted core sees wait=1.

Test Plan:
- Core0 iREN, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with 0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait[0] low one cycle with iload[0]=0xDEADBEEF; iwait[1] stays 1.
- Both cores iREN continuously, RAM always ACCESS -> grants alternate 0,1,0,1.
- Core0 dREN+cctrans, ccwrite=1, daddr=0x100; core1 answers cctrans=1, dWEN=0 -> ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=1; then two RAM reads at 0x100/0x104, two dwait[0] pulses.
- Core1 fill of 0x200; core0 holds M: cctrans[0]=1, dWEN[0]=1, dstore 0x11 then 0x22 -> RAM writes 0x11/0x22; dload[1] equals them in the same cycles; dwait[0] and dwait[1] pulse together twice.
- Core0 dWEN and core1 iREN raised in the same cycle -> writeback wins; IF is granted only after WB1 completes.
- nRST low during LD1 -> next cycle all waits 1, ramREN=0, state IDLE; a reissued request is serviced normally.

Source files
------------

// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two per-core cache pairs, the controller and the RAM port.
// The controller connects through the slave modport. The caches and the RAM drive through master.
interface coherence_bus_ctrl_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    // instruction side
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0][WORD_W-1:0] iload;
    // data side
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][WORD_W-1:0] daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    // coherence
    logic [CPUS-1:0]             ccwrite;
    logic [CPUS-1:0]             cctrans;
    logic [CPUS-1:0]             ccwait;
    logic [CPUS-1:0]             ccinv;
    logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr;
    // RAM port
    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    logic [1:0]                  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI memory controller. It arbitrates icache fetches, dcache fills and writebacks
// onto one RAM port. It snoops the other dcache and forwards Modified blocks cache-to-cache.
// Only one transaction is in flight. Each block is two words, and each word takes one RAM access.
module coherence_bus_ctrl #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    coherence_bus_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, WB0, WB1, SNOOP, LD0, LD1, C2C0, C2C1, IFETCH
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t            state_q, state_d;
    logic              req_q, req_d;     // granted core
    logic              drr_q, drr_d;     // dcache round-robin pointer (favoured core)
    logic              irr_q, irr_d;     // icache round-robin pointer
    logic [WORD_W-1:0] addr_q, addr_d;   // block address latched at grant, used for snooping
    logic              ready;
    logic              oth;
    logic              g;

    assign ready = (bus.ramstate == RAM_ACCESS);
    assign oth   = ~req_q;

    // If both cores request, the pointer breaks the tie. Otherwise the lone requester wins.
    function automatic logic pick(input logic [1:0] v, input logic ptr);
        return (v[0] & v[1]) ? ptr : v[1];
    endfunction

    // State, grant and pointer registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            drr_q   <= 1'b0;
            irr_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            drr_q   <= drr_d;
            irr_q   <= irr_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic and bus outputs. Completion pulses follow ramstate combinationally.
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        drr_d           = drr_q;
        irr_d           = irr_q;
        addr_d          = addr_q;
        g               = 1'b0;
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        for (int n = 0; n < CPUS; n++) begin
            bus.iload[n] = bus.ramload;
            bus.dload[n] = bus.ramload;
        end

        case (state_q)
            IDLE: begin
                if (|bus.dWEN) begin
                    g       = pick(bus.dWEN, drr_q);
                    req_d   = g;
                    addr_d  = bus.daddr[g];
                    state_d = WB0;
                end else if (|bus.dREN) begin
                    g       = pick(bus.dREN, drr_q);
                    req_d   = g;
                    addr_d  = bus.daddr[g];
                    state_d = SNOOP;
                end else if (|bus.iREN) begin
                    g       = pick(bus.iREN, irr_q);
                    req_d   = g;
                    addr_d  = bus.iaddr[g];
                    state_d = IFETCH;
                end
            end
            WB0, WB1: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr[req_q];
                bus.ramstore = bus.dstore[req_q];
                if (ready) begin
                    bus.dwait[req_q] = 1'b0;
                    if (state_q == WB0) state_d = WB1;
                    else begin
                        state_d = IDLE;
                        drr_d   = ~drr_q;
                    end
                end
            end
            SNOOP: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = addr_q;
                bus.ccinv[oth]       = bus.ccwrite[req_q];
                if (bus.cctrans[oth]) state_d = bus.dWEN[oth] ? C2C0 : LD0;
            end
            LD0, LD1: begin
                bus.ramREN      = 1'b1;
                bus.ramaddr     = bus.daddr[req_q];
                bus.ccwait[oth] = 1'b1;
                if (ready) begin
                    bus.dwait[req_q] = 1'b0;
                    if (state_q == LD0) state_d = LD1;
                    else begin
                        state_d = IDLE;
                        drr_d   = ~drr_q;
                    end
                end
            end
            C2C0, C2C1: begin
                // The snooper's dirty word goes to RAM and to the requester at the same time.
                bus.ramWEN       = 1'b1;
                bus.ramaddr      = bus.daddr[oth];
                bus.ramstore     = bus.dstore[oth];
                bus.dload[req_q] = bus.dstore[oth];
                bus.ccwait[oth]  = 1'b1;
                if (ready) begin
                    bus.dwait[oth]   = 1'b0;
                    bus.dwait[req_q] = 1'b0;
                    if (state_q == C2C0) state_d = C2C1;
                    else begin
                        state_d = IDLE;
                        drr_d   = ~drr_q;
                    end
                end
            end
            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[req_q];
                if (ready) begin
                    bus.iwait[req_q] = 1'b0;
                    state_d          = IDLE;
                    irr_d            = ~irr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl. The bench plays both caches and the RAM, one cycle at a time.
module tb_coherence_bus_ctrl;
    logic CLK = 1'b0;
    logic nRST;
    int   tests = 0;
    int   fails = 0;

    coherence_bus_ctrl_if #(.CPUS(2), .WORD_W(32)) bus ();

    coherence_bus_ctrl #(.CPUS(2), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Step past the next rising edge. Inputs are driven after this point, well clear of the edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs();
        bus.iREN = '0;  bus.iaddr = '0;
        bus.dREN = '0;  bus.dWEN = '0;  bus.daddr = '0;  bus.dstore = '0;
        bus.ccwrite = '0;  bus.cctrans = '0;
        bus.ramload = '0;  bus.ramstate = 2'd0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.iwait !== 2'b11) begin fails++; $display("FAIL reset_iwait got %b want 11", bus.iwait); end
        tests++; if (bus.dwait !== 2'b11) begin fails++; $display("FAIL reset_dwait got %b want 11", bus.dwait); end
        tests++; if (bus.ccwait !== 2'b00 || bus.ccinv !== 2'b00) begin fails++; $display("FAIL reset_cc got %b/%b want 00/00", bus.ccwait, bus.ccinv); end
        tests++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin fails++; $display("FAIL reset_ram got %b%b want 00", bus.ramREN, bus.ramWEN); end
        tests++; if (bus.ccsnoopaddr !== 64'h0) begin fails++; $display("FAIL reset_snoopaddr got %h want 0", bus.ccsnoopaddr); end
    endtask

    task automatic test_ifetch();
        do_reset();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h40;
        tick();                         // now IF
        bus.ramstate = 2'd1; #1;
        tests++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin fails++; $display("FAIL if_req got ren=%b addr=%h want 1/40", bus.ramREN, bus.ramaddr); end
        tests++; if (bus.iwait !== 2'b11) begin fails++; $display("FAIL if_busy_wait got %b want 11", bus.iwait); end
        tick(); #1;
        tests++; if (bus.iwait !== 2'b11) begin fails++; $display("FAIL if_busy2_wait got %b want 11", bus.iwait); end
        tick();
        bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF; #1;
        tests++; if (bus.iwait !== 2'b10) begin fails++; $display("FAIL if_done_wait got %b want 10", bus.iwait); end
        tests++; if (bus.iload[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL if_iload got %h want deadbeef", bus.iload[0]); end
        tick();
        bus.iREN = 2'b00; bus.ramstate = 2'd0; #1;
        tests++; if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin fails++; $display("FAIL if_idle got wait=%b ren=%b want 11/0", bus.iwait, bus.ramREN); end
    endtask

    task automatic test_rr_ifetch();
        logic [1:0] want;
        do_reset();
        bus.iREN = 2'b11; bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.ramstate = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;                 // IF for grant k
            want = (k % 2 == 0) ? 2'b10 : 2'b01;
            tests++; if (bus.iwait !== want) begin fails++; $display("FAIL rr_grant%0d got %b want %b", k, bus.iwait, want); end
            tick();                     // back through IDLE
        end
        clear_inputs();
    endtask

    task automatic test_snoop_ld();
        do_reset();
        bus.dREN = 2'b01; bus.cctrans = 2'b01; bus.ccwrite = 2'b01; bus.daddr[0] = 32'h100;
        tick(); #1;                     // SNOOP
        tests++; if (bus.ccwait !== 2'b10 || bus.ccinv !== 2'b10) begin fails++; $display("FAIL snoop_cc got %b/%b want 10/10", bus.ccwait, bus.ccinv); end
        tests++; if (bus.ccsnoopaddr[1] !== 32'h100) begin fails++; $display("FAIL snoop_addr got %h want 100", bus.ccsnoopaddr[1]); end
        tests++; if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin fails++; $display("FAIL snoop_hold got ren=%b dwait=%b want 0/11", bus.ramREN, bus.dwait); end
        bus.cctrans = 2'b11;            // snooper answers without dirty data
        tick();                         // LD0
        bus.cctrans = 2'b01; bus.ramstate = 2'd2; bus.ramload = 32'hA0; #1;
        tests++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h100) begin fails++; $display("FAIL ld0_ram got %b%b %h want 10 100", bus.ramREN, bus.ramWEN, bus.ramaddr); end
        tests++; if (bus.dwait !== 2'b10 || bus.dload[0] !== 32'hA0 || bus.ccwait !== 2'b10) begin fails++; $display("FAIL ld0_done got %b %h %b want 10 a0 10", bus.dwait, bus.dload[0], bus.ccwait); end
        tick();                         // LD1
        bus.daddr[0] = 32'h104; bus.ramload = 32'hA1; #1;
        tests++; if (bus.ramaddr !== 32'h104 || bus.dwait !== 2'b10 || bus.dload[0] !== 32'hA1) begin fails++; $display("FAIL ld1 got %h %b %h want 104 10 a1", bus.ramaddr, bus.dwait, bus.dload[0]); end
        tick();
        clear_inputs(); #1;
        tests++; if (bus.ccwait !== 2'b00 || bus.ramREN !== 1'b0) begin fails++; $display("FAIL ld_idle got %b %b want 00 0", bus.ccwait, bus.ramREN); end
    endtask

    task automatic test_c2c();
        do_reset();
        bus.dREN = 2'b10; bus.cctrans = 2'b10; bus.daddr[1] = 32'h200;
        tick(); #1;                     // SNOOP of core0
        tests++; if (bus.ccwait !== 2'b01 || bus.ccinv !== 2'b00 || bus.ccsnoopaddr[0] !== 32'h200) begin fails++; $display("FAIL c2c_snoop got %b %b %h want 01 00 200", bus.ccwait, bus.ccinv, bus.ccsnoopaddr[0]); end
        bus.cctrans = 2'b11; bus.dWEN = 2'b01; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'h11;
        tick();                         // C2C0
        bus.ramstate = 2'd2; bus.ramload = 32'hFFFF; #1;
        tests++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'h11) begin fails++; $display("FAIL c2c0_ram got %b%b %h %h want 01 200 11", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore); end
        tests++; if (bus.dload[1] !== 32'h11 || bus.dwait !== 2'b00) begin fails++; $display("FAIL c2c0_fwd got %h %b want 11 00", bus.dload[1], bus.dwait); end
        tick();                         // C2C1
        bus.daddr[0] = 32'h204; bus.daddr[1] = 32'h204; bus.dstore[0] = 32'h22; #1;
        tests++; if (bus.ramaddr !== 32'h204 || bus.ramstore !== 32'h22 || bus.dload[1] !== 32'h22 || bus.dwait !== 2'b00) begin fails++; $display("FAIL c2c1 got %h %h %h %b want 204 22 22 00", bus.ramaddr, bus.ramstore, bus.dload[1], bus.dwait); end
        tick();
        clear_inputs(); #1;
        tests++; if (bus.ramWEN !== 1'b0 || bus.ccwait !== 2'b00 || bus.dwait !== 2'b11) begin fails++; $display("FAIL c2c_idle got %b %b %b want 0 00 11", bus.ramWEN, bus.ccwait, bus.dwait); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.dWEN = 2'b01; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'h55;
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h80; bus.ramstate = 2'd2;
        tick(); #1;                     // WB0 wins over IF
        tests++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h300 || bus.ramstore !== 32'h55) begin fails++; $display("FAIL wb0 got %b %h %h want 1 300 55", bus.ramWEN, bus.ramaddr, bus.ramstore); end
        tests++; if (bus.dwait !== 2'b10 || bus.iwait !== 2'b11) begin fails++; $display("FAIL wb0_wait got %b %b want 10 11", bus.dwait, bus.iwait); end
        tick();                         // WB1
        bus.daddr[0] = 32'h304; bus.dstore[0] = 32'h66; #1;
        tests++; if (bus.ramaddr !== 32'h304 || bus.ramstore !== 32'h66 || bus.iwait !== 2'b11) begin fails++; $display("FAIL wb1 got %h %h %b want 304 66 11", bus.ramaddr, bus.ramstore, bus.iwait); end
        bus.dWEN = 2'b00;
        tick(); #1;                     // IDLE
        tests++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin fails++; $display("FAIL wb_idle got %b%b %b want 00 11", bus.ramREN, bus.ramWEN, bus.iwait); end
        tick(); #1;                     // IF for core1
        tests++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h80 || bus.iwait !== 2'b01) begin fails++; $display("FAIL wb_then_if got %b %h %b want 1 80 01", bus.ramREN, bus.ramaddr, bus.iwait); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dREN = 2'b01; bus.cctrans = 2'b01; bus.daddr[0] = 32'h100;
        tick();                         // SNOOP
        bus.cctrans = 2'b11;
        tick();                         // LD0
        bus.ramstate = 2'd2;
        tick(); #1;                     // LD1
        tests++; if (bus.ramREN !== 1'b1 || bus.dwait !== 2'b10) begin fails++; $display("FAIL mid_ld1 got %b %b want 1 10", bus.ramREN, bus.dwait); end
        nRST = 1'b0;
        tick();
        nRST = 1'b1; bus.ramstate = 2'd0; #1;
        tests++; if (bus.dwait !== 2'b11 || bus.iwait !== 2'b11 || bus.ramREN !== 1'b0 || bus.ccwait !== 2'b00) begin fails++; $display("FAIL mid_reset got %b %b %b %b want 11 11 0 00", bus.dwait, bus.iwait, bus.ramREN, bus.ccwait); end
        tick(); #1;                     // reissued request reaches SNOOP
        tests++; if (bus.ccwait !== 2'b10) begin fails++; $display("FAIL mid_resnoop got %b want 10", bus.ccwait); end
        tick();                         // LD0
        bus.ramstate = 2'd2; #1;
        tests++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.dwait !== 2'b10) begin fails++; $display("FAIL mid_reld got %b %h %b want 1 100 10", bus.ramREN, bus.ramaddr, bus.dwait); end
        clear_inputs();
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_rr_ifetch();
        test_snoop_ld();
        test_c2c();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
